scan_chain_driver: RTL

Tester-side initiator for the scan/boundary-scan chain on the DFT-inserted counter: it accepts one stimulus/expected-response pattern at a time, serially loads the stimulus through `scan_sin`, pulses one capture clock, and unloads the response from `scan_sou`. It compares the response against a masked expectation and reports pass/fail. It sits in the test harness and drives the chain's `sin`/`shift`/`test`/`tck` pins, and it is the other end of the `sou` output.

---
 rtl/scan_drv_pkg.sv | 28 ++
 rtl/scan_drv_misr.sv | 25 ++
 rtl/scan_chain_driver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/scan_drv_pkg.sv
// Shared types and constants for the scan chain driver: FSM states, tck phase, MISR parameters.
// The MISR constants are only consumed when SCAN_DRV_MISR_EN is defined.
package scan_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_REPORT
  } drv_state_e;

  // TCK_LOW means the next clk edge raises scan_tck; TCK_HIGH means it drops it.
  typedef enum logic {
    TCK_LOW  = 1'b0,
    TCK_HIGH = 1'b1
  } tck_phase_e;

  localparam int          MISR_W    = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [MISR_W-1:0] data);
    misr_next = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0) ^ data;
  endfunction

endpackage

// File: rtl/scan_drv_misr.sv
// 16-bit parallel-input MISR (x^16+x^12+x^5+1) folding one response word per update.
// Only instantiated by scan_chain_driver when SCAN_DRV_MISR_EN is defined.
module scan_drv_misr
  import scan_drv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              update_i,
  input  logic [MISR_W-1:0] data_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= MISR_SEED;
    end else if (update_i) begin
      sig_q <= misr_next(sig_q, data_i);
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/scan_chain_driver.sv
// Tester-side scan initiator: load stimulus, pulse one capture tck, unload and compare the response.
// Optional SCAN_DRV_MISR_EN adds the misr_sig signature output.
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_stim,
  input  logic [CHAIN_LEN-1:0] pat_expect,
  input  logic [CHAIN_LEN-1:0] pat_mask,
  output logic                 scan_sin,
  input  logic                 scan_sou,
  output logic                 scan_shift,
  output logic                 scan_test,
  output logic                 scan_tck,
  output logic                 res_valid,
  output logic                 res_fail,
  output logic [CHAIN_LEN-1:0] res_resp,
  output logic [CNT_W-1:0]     fail_cnt
`ifdef SCAN_DRV_MISR_EN
  ,
  output logic [MISR_W-1:0]    misr_sig
`endif
);

  localparam int             BCW      = $clog2(CHAIN_LEN);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);

  drv_state_e           state_q;
  tck_phase_e           phase_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [CHAIN_LEN-1:0] stim_q;
  logic [CHAIN_LEN-1:0] expect_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic [CHAIN_LEN-1:0] resp_sr_q;
  logic [CHAIN_LEN-1:0] res_resp_q;
  logic                 sin_q;
  logic                 shift_q;
  logic                 test_q;
  logic                 ready_q;
  logic                 res_valid_q;
  logic                 res_fail_q;
  logic [CNT_W-1:0]     fail_cnt_q;

  logic                 last_bit;
  logic                 unload_done;
  logic                 fail_d;
  logic [CNT_W-1:0]     fail_cnt_d;

  assign last_bit    = (bit_cnt_q == LAST_BIT);
  assign unload_done = (state_q == ST_UNLOAD) && (phase_q == TCK_HIGH) && last_bit;

  always_comb begin
    fail_d     = |((resp_sr_q ^ expect_q) & mask_q);
    fail_cnt_d = fail_cnt_q;
    if (fail_d && (fail_cnt_q != '1)) begin
      fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end
  end

  // Every scan pin change happens on a tck-low edge, so the chain sees a full clk of setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= TCK_LOW;
      bit_cnt_q   <= '0;
      stim_q      <= '0;
      expect_q    <= '0;
      mask_q      <= '0;
      resp_sr_q   <= '0;
      res_resp_q  <= '0;
      sin_q       <= 1'b0;
      shift_q     <= 1'b0;
      test_q      <= 1'b0;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_fail_q  <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pat_valid && ready_q) begin
            stim_q    <= {pat_stim[CHAIN_LEN-2:0], 1'b0};
            expect_q  <= pat_expect;
            mask_q    <= pat_mask;
            sin_q     <= pat_stim[CHAIN_LEN-1];
            shift_q   <= 1'b1;
            test_q    <= 1'b1;
            ready_q   <= 1'b0;
            bit_cnt_q <= '0;
            phase_q   <= TCK_LOW;
            state_q   <= ST_LOAD;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (phase_q == TCK_LOW) begin
            phase_q <= TCK_HIGH;
          end else begin
            phase_q <= TCK_LOW;
            if (last_bit) begin
              shift_q   <= 1'b0;
              sin_q     <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= ST_CAPTURE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
              sin_q     <= stim_q[CHAIN_LEN-1];
              stim_q    <= {stim_q[CHAIN_LEN-2:0], 1'b0};
            end
          end
        end
        ST_CAPTURE: begin
          if (phase_q == TCK_LOW) begin
            phase_q <= TCK_HIGH;
          end else begin
            phase_q <= TCK_LOW;
            shift_q <= 1'b1;
            state_q <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          // scan_sou is taken on the rising-tck edge, before the chain advances.
          if (phase_q == TCK_LOW) begin
            phase_q   <= TCK_HIGH;
            resp_sr_q <= {resp_sr_q[CHAIN_LEN-2:0], scan_sou};
          end else begin
            phase_q <= TCK_LOW;
            if (unload_done) begin
              shift_q     <= 1'b0;
              res_valid_q <= 1'b1;
              res_fail_q  <= fail_d;
              res_resp_q  <= resp_sr_q;
              fail_cnt_q  <= fail_cnt_d;
              bit_cnt_q   <= '0;
              state_q     <= ST_REPORT;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        ST_REPORT: begin
          test_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pat_ready  = ready_q;
  assign scan_sin   = sin_q;
  assign scan_shift = shift_q;
  assign scan_test  = test_q;
  assign scan_tck   = (phase_q == TCK_HIGH);
  assign res_valid  = res_valid_q;
  assign res_fail   = res_fail_q;
  assign res_resp   = res_resp_q;
  assign fail_cnt   = fail_cnt_q;

`ifdef SCAN_DRV_MISR_EN
  localparam int FOLD = (CHAIN_LEN + MISR_W - 1) / MISR_W;

  logic [FOLD*MISR_W-1:0] misr_padded;
  logic [MISR_W-1:0]      misr_data;

  // Wide chains are XOR-folded into 16 bits; narrow ones are simply zero-extended.
  always_comb begin
    misr_padded = (FOLD*MISR_W)'(resp_sr_q & mask_q);
    misr_data   = '0;
    for (int k = 0; k < FOLD; k++) begin
      misr_data = misr_data ^ misr_padded[k*MISR_W +: MISR_W];
    end
  end

  scan_drv_misr u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .update_i (unload_done),
    .data_i   (misr_data),
    .sig_o    (misr_sig)
  );
`endif

endmodule
